controle_display: RTL and testbench
===================================

# controle_display

Sequential controller that converts a 16-bit two's-complement value from the CPU into six digit codes and per-digit enables for six instances of the team's seven-segment `Display` decoder. It uses an iterative shift-add-3 (double-dabble) binary-to-BCD conversion, then leading-zero blanking and minus-sign placement. Results are double-buffered, so the displays show the previous value until a conversion finishes. It sits between the CPU's display output register and the `Display` decoders.

## Interface
- No parameters; widths fixed (16-bit value, 6 digit positions).
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- escrever  input  1  load strobe; samples `valor` when accepted
- valor  input  16  two's-complement value to display
- ocupado  output  1  high while a conversion is in progress
- pronto  output  1  one-cycle pulse when new outputs are valid
- digitos  output  24  six 4-bit codes; nibble i (bits 4i+3:4i) drives `entrada` of Display i; i=0 is units
- habilita  output  6  bit i drives `sinalSaida` of Display i (0 = blank)

## Operation
- States: OCIOSO, CONVERTE, FORMATA.
- OCIOSO with `escrever`=1:
  - latch sign = `valor[15]` and magnitude = |valor| as 16-bit unsigned; −32768 gives 32768.
  - clear 20-bit BCD accumulator and 4-bit step counter; go to CONVERTE.
- CONVERTE, each cycle, one double-dabble step:
  - add 3 to every BCD nibble ≥5;
  - shift {BCD, magnitude} left by 1;
  - increment counter.
  - After the 16th step, go to FORMATA.
- FORMATA, one cycle: with BCD nibbles d4..d0, msd = highest i with di≠0, or 0 if all zero.
  - For i≤msd: digitos nibble i = di, habilita[i]=1.
  - If sign=1: nibble msd+1 = 4'd10 (minus code), habilita[msd+1]=1.
  - All other positions: nibble = 4'hF, habilita[i]=0.
  - Update the output registers, assert `pronto`, return to OCIOSO.
- `escrever` is ignored outside OCIOSO; no queueing.
- Zero displays as a single "0": habilita=6'b000001.
- Sign position never exceeds 5, because msd≤4.

## Timing
- Reset values: state OCIOSO, ocupado=0, pronto=0, digitos=24'h000000, habilita=6'b000000 (all blank).
- Let edge E0 be the edge at which `escrever` is accepted.
  - E0: state becomes CONVERTE.
  - E1..E16: the 16 conversion steps.
  - E17: FORMATA writes the outputs.
- `ocupado` is high from after E0 through after E16, i.e. 17 cycles.
- `digitos`/`habilita` change only at E17 and hold their prior values until then.
- `pronto` is high for exactly the cycle after E17. `ocupado` is 0 in that cycle.
- `escrever` asserted in the `pronto` cycle is accepted: back-to-back throughput is 18 cycles per value.
- `reset` mid-conversion takes priority:
  - next edge gives reset values; the in-flight value is discarded and outputs blank;
  - `escrever` in the same cycle as `reset` is ignored.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset:
  - assert `reset` 2 cycles → digitos=24'h000000, habilita=000000, ocupado=0, pronto=0.
  - Then `escrever` valor=0 → after 18 cycles pronto pulse; digitos nibble0=0, habilita=000001.
- Positive value:
  - valor=1234 → nibbles 4,3,2,1 in positions 0..3, positions 4,5 = F; habilita=001111.
  - `pronto` exactly one cycle after the 17th edge after acceptance.
- Negative values:
  - valor=−7 (16'hFFF9) → nibble0=7, nibble1=10, others F; habilita=000011.
  - valor=−32768 → nibbles 8,6,7,2,3,10; habilita=111111.
- Extremes and internal zeros:
  - valor=32767 → nibbles 7,6,7,2,3,F; habilita=011111.
  - valor=100 → nibbles 0,0,1; habilita=000111 (internal zeros shown).
- Handshake:
  - `escrever` with 55 accepted; `escrever` with 99 while ocupado → ignored, result shows 55.
  - `escrever` 42 in the `pronto` cycle → accepted; next `pronto` 18 cycles later shows 42.
  - Old digits stay stable during conversion.
- Reset mid-conversion:
  - accept valor=999, assert `reset` at step 8 → outputs reset values, ocupado=0.
  - No `pronto` follows; a new `escrever` converts normally.

Source files
------------

// File: rtl/controle_display.sv
// rtl/controle_display.sv - 16-bit signed value to six-digit display codes via iterative double-dabble
module controle_display (
    input  logic        clock,
    input  logic        reset,
    input  logic        escrever,
    input  logic [15:0] valor,
    output logic        ocupado,
    output logic        pronto,
    output logic [23:0] digitos,
    output logic [5:0]  habilita
);

    localparam logic [1:0] OCIOSO   = 2'd0;
    localparam logic [1:0] CONVERTE = 2'd1;
    localparam logic [1:0] FORMATA  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        sign_q, sign_d;
    logic [15:0] mag_q, mag_d;
    logic [19:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [23:0] dig_q, dig_d;
    logic [5:0]  hab_q, hab_d;
    logic        pronto_q, pronto_d;
    logic        ocupado_q, ocupado_d;

    logic [19:0] bcd_adj;
    logic [23:0] bcd_ext;
    logic [2:0]  msd;
    logic [23:0] fmt_dig;
    logic [5:0]  fmt_hab;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Position 5 can only ever hold the minus sign, so it reads a zero pad here.
    always_comb begin
        bcd_ext = {4'h0, bcd_q};
        msd     = 3'd0;
        for (int i = 1; i < 5; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                msd = 3'(i);
            end
        end
        fmt_dig = 24'hFFFFFF;
        fmt_hab = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            if (3'(i) <= msd) begin
                fmt_dig[4*i +: 4] = bcd_ext[4*i +: 4];
                fmt_hab[i]        = 1'b1;
            end else if (sign_q && (3'(i) == msd + 3'd1)) begin
                fmt_dig[4*i +: 4] = 4'd10;
                fmt_hab[i]        = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        dig_d    = dig_q;
        hab_d    = hab_q;
        pronto_d = 1'b0;
        case (state_q)
            OCIOSO: begin
                if (escrever) begin
                    sign_d  = valor[15];
                    mag_d   = valor[15] ? (~valor + 16'd1) : valor;
                    bcd_d   = 20'd0;
                    cnt_d   = 4'd0;
                    state_d = CONVERTE;
                end
            end
            CONVERTE: begin
                {bcd_d, mag_d} = {bcd_adj[18:0], mag_q, 1'b0};
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = FORMATA;
                end
            end
            FORMATA: begin
                dig_d    = fmt_dig;
                hab_d    = fmt_hab;
                pronto_d = 1'b1;
                state_d  = OCIOSO;
            end
            default: begin
                state_d = OCIOSO;
            end
        endcase
        ocupado_d = (state_d != OCIOSO);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= OCIOSO;
            sign_q    <= 1'b0;
            mag_q     <= 16'd0;
            bcd_q     <= 20'd0;
            cnt_q     <= 4'd0;
            dig_q     <= 24'h000000;
            hab_q     <= 6'b000000;
            pronto_q  <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            dig_q     <= dig_d;
            hab_q     <= hab_d;
            pronto_q  <= pronto_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign ocupado  = ocupado_q;
    assign pronto   = pronto_q;
    assign digitos  = dig_q;
    assign habilita = hab_q;

endmodule

// File: tb/tb_controle_display.sv
// tb/tb_controle_display.sv - table-driven, scoreboarded bench for controle_display
module tb_controle_display;

    logic        clock;
    logic        reset;
    logic        escrever;
    logic [15:0] valor;
    logic        ocupado;
    logic        pronto;
    logic [23:0] digitos;
    logic [5:0]  habilita;

    controle_display dut (
        .clock    (clock),
        .reset    (reset),
        .escrever (escrever),
        .valor    (valor),
        .ocupado  (ocupado),
        .pronto   (pronto),
        .digitos  (digitos),
        .habilita (habilita)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] v;
        logic [23:0] d;
        logic [5:0]  h;
    } vec_t;

    typedef struct {
        logic [23:0] d;
        logic [5:0]  h;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [23:0] snap_dig;
    logic [5:0]  snap_hab;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Decimal reference: digit extraction by division, independent of double-dabble.
    task automatic model(input logic [15:0] v, output logic [23:0] d, output logic [5:0] h);
        int m;
        int ds[5];
        int top;
        m = int'($signed(v));
        if (m < 0) m = -m;
        top = 0;
        for (int i = 0; i < 5; i++) begin
            ds[i] = m % 10;
            m     = m / 10;
            if (ds[i] != 0) top = i;
        end
        d = 24'hFFFFFF;
        h = 6'b000000;
        for (int i = 0; i <= top; i++) begin
            d[4*i +: 4] = 4'(ds[i]);
            h[i]        = 1'b1;
        end
        if (v[15]) begin
            d[4*(top+1) +: 4] = 4'd10;
            h[top+1]          = 1'b1;
        end
    endtask

    always @(negedge clock) begin
        if (pronto) begin
            if (sb.size() == 0) begin
                chk("unexpected_pronto", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("digitos", {8'h0, digitos}, {8'h0, e.d});
                chk("habilita", {26'h0, habilita}, {26'h0, e.h});
            end
        end
    end

    // Called at a negedge while idle; returns at the negedge after the accepting edge.
    task automatic accept(input logic [15:0] v, input logic [23:0] d, input logic [5:0] h);
        exp_t e;
        snap_dig = digitos;
        snap_hab = habilita;
        e.d = d;
        e.h = h;
        sb.push_back(e);
        escrever = 1'b1;
        valor    = v;
        @(negedge clock);
        escrever = 1'b0;
    endtask

    task automatic wait_pronto(input int start, input string name);
        int lat;
        int bad_busy;
        int bad_hold;
        lat      = start;
        bad_busy = 0;
        bad_hold = 0;
        while (!pronto && lat < 40) begin
            if (!ocupado) bad_busy++;
            if (digitos !== snap_dig || habilita !== snap_hab) bad_hold++;
            @(negedge clock);
            lat++;
        end
        chk({name, "_latency"}, lat, 18);
        chk({name, "_busy"}, bad_busy, 0);
        chk({name, "_hold"}, bad_hold, 0);
        chk({name, "_busy_in_pronto"}, {31'h0, ocupado}, 32'd0);
    endtask

    task automatic run_one(input logic [15:0] v, input logic [23:0] d, input logic [5:0] h, input string name);
        accept(v, d, h);
        wait_pronto(1, name);
        @(negedge clock);
        chk({name, "_pronto_width"}, {31'h0, pronto}, 32'd0);
    endtask

    vec_t tab[10];

    initial begin
        logic [23:0] md;
        logic [5:0]  mh;
        int          np;

        tab[0] = '{16'd0,     24'hFFFFF0, 6'b000001};
        tab[1] = '{16'd1234,  24'hFF1234, 6'b001111};
        tab[2] = '{16'hFFF9,  24'hFFFFA7, 6'b000011};
        tab[3] = '{16'h8000,  24'hA32768, 6'b111111};
        tab[4] = '{16'd32767, 24'hF32767, 6'b011111};
        tab[5] = '{16'd100,   24'hFFF100, 6'b000111};
        tab[6] = '{16'hFFFF,  24'hFFFFA1, 6'b000011};
        tab[7] = '{16'hFF9C,  24'hFFA100, 6'b001111};
        tab[8] = '{16'hD8F1,  24'hFA9999, 6'b011111};
        tab[9] = '{16'd10000, 24'hF10000, 6'b011111};

        reset    = 1'b1;
        escrever = 1'b0;
        valor    = 16'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_digitos", {8'h0, digitos}, 32'h0);
        chk("rst_habilita", {26'h0, habilita}, 32'h0);
        chk("rst_ocupado", {31'h0, ocupado}, 32'h0);
        chk("rst_pronto", {31'h0, pronto}, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            run_one(tab[i].v, tab[i].d, tab[i].h, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 4; i++) begin
            logic [15:0] rv;
            rv = 16'($urandom);
            model(rv, md, mh);
            run_one(rv, md, mh, $sformatf("rand%0d", i));
        end

        // 99 arrives while busy and must be dropped; 42 arrives in the pronto cycle.
        accept(16'd55, 24'hFFFF55, 6'b000011);
        @(negedge clock);
        escrever = 1'b1;
        valor    = 16'd99;
        @(negedge clock);
        escrever = 1'b0;
        wait_pronto(3, "busy_ignore");
        accept(16'd42, 24'hFFFF42, 6'b000011);
        wait_pronto(1, "back_to_back");
        @(negedge clock);

        // Reset during step 8, with escrever high in the same cycle.
        accept(16'd999, 24'hFFF999, 6'b000111);
        repeat (7) @(negedge clock);
        reset    = 1'b1;
        escrever = 1'b1;
        valor    = 16'd5;
        @(negedge clock);
        sb.delete();
        chk("midrst_digitos", {8'h0, digitos}, 32'h0);
        chk("midrst_habilita", {26'h0, habilita}, 32'h0);
        chk("midrst_ocupado", {31'h0, ocupado}, 32'h0);
        chk("midrst_pronto", {31'h0, pronto}, 32'h0);
        reset    = 1'b0;
        escrever = 1'b0;
        np = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            if (pronto || ocupado) np++;
        end
        chk("midrst_quiet", np, 0);
        run_one(16'hFC19, 24'hFFA999, 6'b001111, "after_rst");

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
